interp_pwl_pipe: RTL

//  Parametrised piecewise-linear interpolator; successor to the fixed 8-weight interpolator top.

---
 rtl/interp_pkg.sv | 34 +++
 rtl/interp_weight_rf.sv | 44 ++++
 rtl/interp_pwl_pipe.sv | 126 ++++++++++++
 3 files changed

// File: rtl/interp_pkg.sv
// Shared widths, derivation helpers and default-configuration payload types for the PWL interpolator.
package interp_pkg;

  localparam int DEF_X_W   = 8;
  localparam int DEF_N_PTS = 8;
  localparam int DEF_W_W   = 12;

  function automatic int seg_w(input int n_pts);
    return $clog2(n_pts);
  endfunction

  function automatic int frac_w(input int x_w, input int n_pts);
    return x_w - $clog2(n_pts);
  endfunction

  localparam int DEF_SEG_W  = seg_w(DEF_N_PTS);
  localparam int DEF_FRAC_W = frac_w(DEF_X_W, DEF_N_PTS);

  typedef logic signed [DEF_W_W-1:0]            weight_t;
  typedef logic signed [DEF_W_W:0]              diff_t;
  typedef logic signed [DEF_W_W+DEF_FRAC_W:0]   prod_t;

  typedef struct packed {
    weight_t                w_lo;
    diff_t                  diff;
    logic [DEF_FRAC_W-1:0]  frac;
  } s1_payload_t;

  typedef struct packed {
    weight_t w_lo;
    prod_t   prod;
  } s2_payload_t;

endpackage

// File: rtl/interp_weight_rf.sv
// Breakpoint register file: one write port, two combinational read ports.
// Reads return the pre-write contents during a write cycle.
module interp_weight_rf
  import interp_pkg::*;
#(
  parameter int N_PTS = DEF_N_PTS,
  parameter int W_W   = DEF_W_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [seg_w(N_PTS)-1:0]     wr_addr,
  input  logic signed [W_W-1:0]       wr_data,
  input  logic [seg_w(N_PTS)-1:0]     rd_lo_addr,
  input  logic [seg_w(N_PTS)-1:0]     rd_hi_addr,
  output logic signed [W_W-1:0]       rd_lo_data,
  output logic signed [W_W-1:0]       rd_hi_data
);

  localparam int SEG_W = seg_w(N_PTS);

  logic [W_W-1:0] mem_q [N_PTS];
  logic [W_W-1:0] mem_d [N_PTS];

  always_comb begin
    for (int i = 0; i < N_PTS; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (wr_addr == SEG_W'(i))) mem_d[i] = wr_data;
    end
  end

  // rst_n is the legacy active-high asynchronous reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < N_PTS; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PTS; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_lo_data = mem_q[rd_lo_addr];
  assign rd_hi_data = mem_q[rd_hi_addr];

endmodule

// File: rtl/interp_pwl_pipe.sv
// Three-stage piecewise-linear interpolator with a global-stall valid/ready pipeline.
// Define INTERP_ROUND_EN to round the fractional step half toward +inf instead of flooring.
module interp_pwl_pipe
  import interp_pkg::*;
#(
  parameter int X_W   = DEF_X_W,
  parameter int N_PTS = DEF_N_PTS,
  parameter int W_W   = DEF_W_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [seg_w(N_PTS)-1:0]  wr_addr,
  input  logic [W_W-1:0]           wr_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [X_W-1:0]           in_x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W_W-1:0]           out_y
);

  localparam int SEG_W  = seg_w(N_PTS);
  localparam int FRAC_W = frac_w(X_W, N_PTS);
  localparam int DIFF_W = W_W + 1;
  localparam int PROD_W = W_W + 1 + FRAC_W;

  typedef logic signed [W_W-1:0]    w_t;
  typedef logic signed [DIFF_W-1:0] d_t;
  typedef logic signed [PROD_W-1:0] p_t;

  typedef struct packed {
    w_t                w_lo;
    d_t                diff;
    logic [FRAC_W-1:0] frac;
  } s1_t;

  typedef struct packed {
    w_t w_lo;
    p_t prod;
  } s2_t;

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic [W_W-1:0]   y_q, y_d;

  logic [SEG_W-1:0] idx_lo, idx_hi;
  w_t               w_lo, w_hi;
  logic             adv;
  p_t               diff_x, frac_x, sum;
  logic [W_W-1:0]   step;

  assign idx_lo = in_x[X_W-1 -: SEG_W];
  // last segment is flat: both ends read the final breakpoint
  assign idx_hi = (idx_lo == SEG_W'(N_PTS - 1)) ? idx_lo : idx_lo + SEG_W'(1);

  interp_weight_rf #(.N_PTS(N_PTS), .W_W(W_W)) u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_lo_addr (idx_lo),
    .rd_hi_addr (idx_hi),
    .rd_lo_data (w_lo),
    .rd_hi_data (w_hi)
  );

  assign adv       = ~v3_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out_y     = y_q;

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    s1_d = s1_q;
    s2_d = s2_q;
    y_d  = y_q;

    diff_x = p_t'($signed(s1_q.diff));
    frac_x = p_t'({1'b0, s1_q.frac});
`ifdef INTERP_ROUND_EN
    sum = $signed(s2_q.prod) + (p_t'(1) <<< (FRAC_W - 1));
`else
    sum = $signed(s2_q.prod);
`endif
    step = W_W'(sum >>> FRAC_W);

    if (adv) begin
      v1_d      = in_valid;
      s1_d.w_lo = w_lo;
      s1_d.diff = d_t'(w_hi) - d_t'(w_lo);
      s1_d.frac = in_x[FRAC_W-1:0];

      v2_d      = v1_q;
      s2_d.w_lo = s1_q.w_lo;
      s2_d.prod = diff_x * frac_x;

      v3_d      = v2_q;
      // result always lies between the two breakpoints, so W_W bits suffice
      y_d       = s2_q.w_lo + step;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      y_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      y_q  <= y_d;
    end
  end

endmodule
